// File: rtl/aes_pkg.sv
// aes_pkg -- shared types and helpers for the iterative AES core.
//   ctrl_state_t : controller state encoding (IDLE, EXPAND, ROUND, DONE)
//   nk(K), nr(K) : key length in 32-bit words and round count for a K-bit key
//   xtime(b)     : multiply-by-x in GF(2^8), used to step the round constant
//   RCON_INIT    : round constant for the first RotWord step of a schedule
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } ctrl_state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic int nk(input int k);
        return k / 32;
    endfunction

    function automatic int nr(input int k);
        return (k / 32) + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen -- round-constant register for the key schedule.
//   clk     : core clock
//   reset   : asynchronous active-high reset, rcon returns to RCON_INIT
//   clear   : reload RCON_INIT at the start of a new schedule
//   advance : step rcon to xtime(rcon) after a RotWord word has used it
//   rcon    : current round constant (high byte of the Rcon word)
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;
    logic [7:0] rcon_d;

    always_comb begin
        rcon_d = rcon_q;
        if (clear) begin
            rcon_d = RCON_INIT;
        end else if (advance) begin
            rcon_d = xtime(rcon_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcon_q <= RCON_INIT;
        end else begin
            rcon_q <= rcon_d;
        end
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- sequencing controller for the iterative AES core.
// After the serial front end loads key and block (falling edge of load), runs
// the key expansion one word per cycle, then steps the round datapath through
// Nr+1 round-key applications (forward, or reversed when INV=1), then holds
// done for the shift-out until load goes high again.
//
// Parameters: K   key length 128/192/256
//             INV 0 = encrypt key order, 1 = inverse-cipher key order
// Ports:
//   clk, reset (async, active high), load (front-end loading flag)
//   busy   : EXPAND or ROUND
//   exp_en, w_idx, rot_en, sub_en, rcon : key-expansion word controls
//   rnd_en, rk_idx, first, last         : round datapath controls
//   done   : result ready for shift-out
// Build option: AES_ROUND_CTRL_ABORT_EN -- a rising edge of load while busy
// aborts the run to IDLE. Without it, load is ignored until DONE.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int K   = 128,
    parameter bit INV = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    output logic       busy,
    output logic       exp_en,
    output logic [5:0] w_idx,
    output logic       rot_en,
    output logic       sub_en,
    output logic [7:0] rcon,
    output logic       rnd_en,
    output logic [3:0] rk_idx,
    output logic       first,
    output logic       last,
    output logic       done
);

    localparam int         NK       = nk(K);
    localparam int         NR       = nr(K);
    localparam logic [5:0] NK_IDX   = 6'(NK);
    localparam logic [5:0] W_LAST   = 6'(4 * NR + 3);
    localparam logic [3:0] NR_IDX   = 4'(NR);
    localparam logic [2:0] MOD_LAST = 3'(NK - 1);
    localparam bit         HAS_SUB  = (NK == 8);

    ctrl_state_t state_q, state_d;
    logic        load_q;
    logic [5:0]  w_idx_q, w_idx_d;
    // w_idx mod Nk, tracked incrementally so no divider is needed
    logic [2:0]  mod_q, mod_d;
    logic [3:0]  r_q, r_d;
    logic        start;
    logic        load_fall;

    assign load_fall = load_q & ~load;

`ifdef AES_ROUND_CTRL_ABORT_EN
    logic load_rise;
    assign load_rise = load & ~load_q;
`endif

    always_comb begin
        state_d = state_q;
        w_idx_d = w_idx_q;
        mod_d   = mod_q;
        r_d     = r_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_fall) begin
                    state_d = ST_EXPAND;
                    w_idx_d = NK_IDX;
                    mod_d   = 3'd0;
                    start   = 1'b1;
                end
            end
            ST_EXPAND: begin
                mod_d = (mod_q == MOD_LAST) ? 3'd0 : mod_q + 3'd1;
                if (w_idx_q == W_LAST) begin
                    // w_idx holds its final value through the rounds
                    state_d = ST_ROUND;
                    r_d     = 4'd0;
                end else begin
                    w_idx_d = w_idx_q + 6'd1;
                end
            end
            ST_ROUND: begin
                if (r_q == NR_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            ST_DONE: begin
                // level, not edge: load already high when DONE is reached
                // still returns to IDLE
                if (load) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
        if ((state_q == ST_EXPAND || state_q == ST_ROUND) && load_rise) begin
            state_d = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            w_idx_q <= 6'd0;
            mod_q   <= 3'd0;
            r_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            load_q  <= load;
            w_idx_q <= w_idx_d;
            mod_q   <= mod_d;
            r_q     <= r_d;
        end
    end

    // Strobes decode registered state only; load never reaches an output.
    always_comb begin
        busy   = 1'b0;
        exp_en = 1'b0;
        rot_en = 1'b0;
        sub_en = 1'b0;
        rnd_en = 1'b0;
        first  = 1'b0;
        last   = 1'b0;
        done   = 1'b0;
        rk_idx = 4'd0;
        case (state_q)
            ST_EXPAND: begin
                busy   = 1'b1;
                exp_en = 1'b1;
                rot_en = (mod_q == 3'd0);
                sub_en = HAS_SUB && (mod_q == 3'd4);
            end
            ST_ROUND: begin
                busy   = 1'b1;
                rnd_en = 1'b1;
                first  = (r_q == 4'd0);
                last   = (r_q == NR_IDX);
                rk_idx = INV ? (NR_IDX - r_q) : r_q;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_idx = w_idx_q;

    // rcon is consumed on the rot_en cycle and stepped right after it
    aes_rcon_gen u_rcon (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .advance (rot_en),
        .rcon    (rcon)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl -- bench for aes_round_ctrl. Three instances (K=128 enc,
// K=192 dec, K=256 enc), each with its own load and reset. A cycle-level model
// predicts every output from the run's elapsed cycle count; literal checks pin
// counts, rcon sequence and done latency. Honours AES_ROUND_CTRL_ABORT_EN.
module tb_aes_round_ctrl;

    localparam int ND = 3;

    function automatic int k_of(input int i);
        case (i)
            0:       return 128;
            1:       return 192;
            default: return 256;
        endcase
    endfunction
    function automatic int inv_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int nk_of(input int i);
        return k_of(i) / 32;
    endfunction
    function automatic int nr_of(input int i);
        return nk_of(i) + 6;
    endfunction
    function automatic int e_of(input int i);
        return 4 * (nr_of(i) + 1) - nk_of(i);
    endfunction
    function automatic int tdone_of(input int i);
        return e_of(i) + nr_of(i) + 1;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [ND-1:0] rst;
    logic [ND-1:0] ld;
    logic [ND-1:0] busy_w, exp_w, rot_w, sub_w, rnd_w, first_w, last_w, done_w;
    logic [5:0]    widx_w [ND];
    logic [7:0]    rcon_w [ND];
    logic [3:0]    rk_w   [ND];

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            aes_round_ctrl #(
                .K   (k_of(gi)),
                .INV (1'(inv_of(gi)))
            ) u_dut (
                .clk    (clk),
                .reset  (rst[gi]),
                .load   (ld[gi]),
                .busy   (busy_w[gi]),
                .exp_en (exp_w[gi]),
                .w_idx  (widx_w[gi]),
                .rot_en (rot_w[gi]),
                .sub_en (sub_w[gi]),
                .rcon   (rcon_w[gi]),
                .rnd_en (rnd_w[gi]),
                .rk_idx (rk_w[gi]),
                .first  (first_w[gi]),
                .last   (last_w[gi]),
                .done   (done_w[gi])
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // FIPS-197 round constants; entry 10 is what the register holds after the
    // tenth step and is visible on the trailing K=128 words.
    logic [7:0] rc_tab [11];

    // model state
    bit run_m   [ND];
    bit pld_m   [ND];
    bit fresh_m [ND];
    int t_m     [ND];

    // per-run observations
    bit         prev_exp  [ND];
    bit         prev_done [ND];
    int         start_cyc [ND];
    int         done_rel  [ND];
    int         n_exp     [ND];
    int         n_rot     [ND];
    int         n_sub     [ND];
    int         n_done_hi [ND];
    logic [5:0] first_widx [ND];
    logic [5:0] last_widx  [ND];
    logic [7:0] first_rcon [ND];
    logic [7:0] last_rot_rc [ND];
    logic [3:0] rk_first [ND];
    logic [3:0] rk_last  [ND];
    logic [7:0] rot_rc [ND][16];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s dut=%0d cyc=%0d got=0x%0h want=0x%0h", nm, i, cyc, act, exp);
        end
    endtask

    // Advance the model on the active edge from the load level seen there.
    task automatic model_step();
        for (int i = 0; i < ND; i++) begin
            if (rst[i]) begin
                run_m[i] = 1'b0; pld_m[i] = 1'b0; fresh_m[i] = 1'b1; t_m[i] = 0;
            end else begin
                if (!run_m[i]) begin
                    if (pld_m[i] && !ld[i]) begin
                        run_m[i] = 1'b1; t_m[i] = 0; fresh_m[i] = 1'b0;
                    end
                end else if (t_m[i] >= tdone_of(i)) begin
                    if (ld[i]) run_m[i] = 1'b0;
                end else begin
`ifdef AES_ROUND_CTRL_ABORT_EN
                    if (ld[i] && !pld_m[i]) run_m[i] = 1'b0;
                    else t_m[i]++;
`else
                    t_m[i]++;
`endif
                end
                pld_m[i] = ld[i];
            end
        end
    endtask

    task automatic compare_and_observe();
        int ph, w, r, nk, nr, e;
        logic [7:0] exp_s;
        for (int i = 0; i < ND; i++) begin
            nk = nk_of(i); nr = nr_of(i); e = e_of(i);
            if (rst[i] || !run_m[i]) ph = 0;
            else if (t_m[i] < e) ph = 1;
            else if (t_m[i] < tdone_of(i)) ph = 2;
            else ph = 3;
            w = nk + t_m[i];
            r = t_m[i] - e;
            exp_s = 8'h00;
            // order: busy exp rot sub rnd first last done
            if (ph == 1) begin
                exp_s[7] = 1'b1; exp_s[6] = 1'b1;
                exp_s[5] = (w % nk == 0);
                exp_s[4] = (nk == 8) && (w % 8 == 4);
            end else if (ph == 2) begin
                exp_s[7] = 1'b1; exp_s[3] = 1'b1;
                exp_s[2] = (r == 0); exp_s[1] = (r == nr);
            end else if (ph == 3) begin
                exp_s[0] = 1'b1;
            end
            chk("strobes", i, 32'({busy_w[i], exp_w[i], rot_w[i], sub_w[i],
                                   rnd_w[i], first_w[i], last_w[i], done_w[i]}), 32'(exp_s));
            if (ph == 1) begin
                chk("w_idx", i, 32'(widx_w[i]), 32'(w));
                chk("rcon", i, 32'(rcon_w[i]), 32'(rc_tab[(w + nk - 1) / nk - 1]));
            end
            if (ph == 2)
                chk("rk_idx", i, 32'(rk_w[i]), 32'(inv_of(i) != 0 ? nr - r : r));
            if (ph == 0 && (rst[i] || fresh_m[i])) begin
                chk("rst_w_idx", i, 32'(widx_w[i]), 32'd0);
                chk("rst_rcon", i, 32'(rcon_w[i]), 32'h01);
                chk("rst_rk_idx", i, 32'(rk_w[i]), 32'd0);
            end

            if (exp_w[i] === 1'b1 && !prev_exp[i]) begin
                start_cyc[i] = cyc; n_exp[i] = 0; n_rot[i] = 0; n_sub[i] = 0;
                n_done_hi[i] = 0; done_rel[i] = -1;
                first_widx[i] = widx_w[i]; first_rcon[i] = rcon_w[i];
            end
            if (exp_w[i] === 1'b1) begin
                n_exp[i]++; last_widx[i] = widx_w[i];
                if (rot_w[i] === 1'b1) begin
                    if (n_rot[i] < 16) rot_rc[i][n_rot[i]] = rcon_w[i];
                    n_rot[i]++; last_rot_rc[i] = rcon_w[i];
                end
                if (sub_w[i] === 1'b1) n_sub[i]++;
            end
            if (first_w[i] === 1'b1) rk_first[i] = rk_w[i];
            if (last_w[i] === 1'b1) rk_last[i] = rk_w[i];
            if (done_w[i] === 1'b1 && !prev_done[i]) done_rel[i] = cyc - start_cyc[i];
            if (done_w[i] === 1'b1) n_done_hi[i]++;
            prev_exp[i]  = (exp_w[i] === 1'b1);
            prev_done[i] = (done_w[i] === 1'b1);
        end
    endtask

    // One clock: model advances on the rising edge, outputs checked on the
    // falling edge, inputs then driven by the caller.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
            compare_and_observe();
        end
    endtask

    task automatic wait_done(input int i, input int bound);
        int n;
        n = 0;
        while (done_w[i] !== 1'b1 && n < bound) begin
            tick(1);
            n++;
        end
        chk("done_wait", i, 32'(done_w[i]), 32'd1);
    endtask

    task automatic full_run(input int i);
        ld[i] = 1'b1;
        tick(256);
        ld[i] = 1'b0;
        wait_done(i, 120);
        tick(4);
        chk("done_held", i, 32'(done_w[i]), 32'd1);
        $display("run dut=%0d K=%0d INV=%0d exp=%0d rot=%0d sub=%0d done_at=%0d",
                 i, k_of(i), inv_of(i), n_exp[i], n_rot[i], n_sub[i], done_rel[i]);
        ld[i] = 1'b1;
        tick(2);
        chk("idle_after_done", i, 32'({busy_w[i], done_w[i]}), 32'd0);
    endtask

    initial begin
        logic [7:0] seq128 [10];
        seq128 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 8'h6c};
        rst = '1;
        ld  = '0;
        tick(3);
        rst = '0;
        tick(2);

        // K=128 encrypt
        full_run(0);
        chk("k128_exp_cycles", 0, 32'(n_exp[0]), 32'd40);
        chk("k128_first_widx", 0, 32'(first_widx[0]), 32'd4);
        chk("k128_last_widx", 0, 32'(last_widx[0]), 32'd43);
        chk("k128_rot_count", 0, 32'(n_rot[0]), 32'd10);
        for (int j = 0; j < 10; j++)
            chk("k128_rcon_seq", 0, 32'(rot_rc[0][j]), 32'(seq128[j]));
        chk("k128_done_at", 0, 32'(done_rel[0]), 32'd51);
        chk("k128_rk_first", 0, 32'(rk_first[0]), 32'd0);
        chk("k128_rk_last", 0, 32'(rk_last[0]), 32'd10);

        // K=192 decrypt
        full_run(1);
        chk("k192_exp_cycles", 1, 32'(n_exp[1]), 32'd46);
        chk("k192_rot_count", 1, 32'(n_rot[1]), 32'd8);
        chk("k192_last_rcon", 1, 32'(last_rot_rc[1]), 32'h80);
        chk("k192_rk_first", 1, 32'(rk_first[1]), 32'd12);
        chk("k192_rk_last", 1, 32'(rk_last[1]), 32'd0);
        chk("k192_sub_count", 1, 32'(n_sub[1]), 32'd0);
        chk("k192_done_at", 1, 32'(done_rel[1]), 32'd59);

        // K=256 encrypt
        full_run(2);
        chk("k256_exp_cycles", 2, 32'(n_exp[2]), 32'd52);
        chk("k256_first_widx", 2, 32'(first_widx[2]), 32'd8);
        chk("k256_sub_count", 2, 32'(n_sub[2]), 32'd6);
        chk("k256_rot_count", 2, 32'(n_rot[2]), 32'd7);
        chk("k256_last_rcon", 2, 32'(last_rot_rc[2]), 32'h40);
        chk("k256_done_at", 2, 32'(done_rel[2]), 32'd67);

        // reset during EXPAND cycle 20, then a clean restart
        ld[0] = 1'b0;
        tick(21);
        chk("pre_rst_widx", 0, 32'(widx_w[0]), 32'd24);
        rst[0] = 1'b1;
        #1;
        chk("rst_now_strobes", 0, 32'({busy_w[0], exp_w[0], rot_w[0], rnd_w[0], done_w[0]}), 32'd0);
        chk("rst_now_widx", 0, 32'(widx_w[0]), 32'd0);
        chk("rst_now_rcon", 0, 32'(rcon_w[0]), 32'h01);
        tick(2);
        rst[0] = 1'b0;
        tick(1);
        ld[0] = 1'b1;
        tick(2);
        ld[0] = 1'b0;
        wait_done(0, 120);
        chk("restart_widx", 0, 32'(first_widx[0]), 32'd4);
        chk("restart_rcon", 0, 32'(first_rcon[0]), 32'h01);
        chk("restart_done_at", 0, 32'(done_rel[0]), 32'd51);
        $display("run dut=0 restart after reset done_at=%0d", done_rel[0]);
        ld[0] = 1'b1;
        tick(2);

        // load raised during ROUND r=5 and held high
        ld[1] = 1'b0;
        tick(e_of(1) + 6);
        chk("r5_rk_idx", 1, 32'(rk_w[1]), 32'd7);
        ld[1] = 1'b1;
`ifdef AES_ROUND_CTRL_ABORT_EN
        tick(1);
        chk("abort_idle", 1, 32'(busy_w[1]), 32'd0);
        tick(20);
        chk("abort_no_done", 1, 32'(n_done_hi[1]), 32'd0);
`else
        wait_done(1, 40);
        chk("nabort_done_at", 1, 32'(done_rel[1]), 32'd59);
        tick(3);
        chk("nabort_done_cycles", 1, 32'(n_done_hi[1]), 32'd1);
        chk("nabort_idle", 1, 32'({busy_w[1], done_w[1]}), 32'd0);
`endif
        $display("run dut=1 load during round, done cycles=%0d", n_done_hi[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
